dac8551_arb: RTL and testbench

Arbiter and sequencer in front of the dac8551 serial driver. It shares the single DAC between two 16-bit requesters: port A (host register writes) and port B (reference loop filter output). Each port has a latest-value-wins pending slot. Requests are granted round-robin. The block enforces a minimum hold-off between DAC frames and re-issues the last code whenever the power-down mode input changes.

---
 rtl/dac8551_arb.sv | 193 +++++++++++++++++++
 tb/tb_dac8551_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac8551_arb.sv
// dac8551_arb: shares one DAC8551 serial driver between two 16-bit requesters.
// Port A and port B each have a latest-value-wins pending slot. Grants go
// round-robin, a hold-off is enforced between frames, and the last code is
// re-sent whenever the power-down mode changes.
// Optional build macro DAC8551_ARB_STATS_EN adds saturating per-port counters
// of coalesced (overwritten) pending values on o_a_drops / o_b_drops.
module dac8551_arb #(
  parameter int HOLDOFF       = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_valid,
  input  logic [15:0] i_a_data,
  input  logic        i_b_valid,
  input  logic [15:0] i_b_data,
  input  logic [1:0]  i_pd_mode,
  output logic        o_dac_wr,
  output logic [23:0] o_dac_wr_data,
  input  logic        i_dac_busy,
  output logic [15:0] o_code,
  output logic        o_src,
  output logic        o_busy
`ifdef DAC8551_ARB_STATS_EN
  ,
  output logic [7:0]  o_a_drops,
  output logic [7:0]  o_b_drops
`endif
);

  localparam int CNT_MAX = (HOLDOFF > START_TIMEOUT) ? HOLDOFF : START_TIMEOUT;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_HOLDOFF
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] slot_a_q, slot_b_q;
  logic        pend_a_q, pend_b_q, pend_pd_q;
  logic [1:0]  mode_q;
  // High when port B was the last data port served, so a tie goes to A.
  logic        rr_b_last_q;

  logic        any_req;
  logic        grant;
  logic        gnt_a, gnt_b;
  logic [15:0] gnt_code;

  // Saturating 8-bit increment for the drop counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Grant selection: a grant only happens from IDLE with the driver quiet.
  always_comb begin
    any_req  = pend_a_q | pend_b_q | pend_pd_q;
    grant    = (state_q == S_IDLE) && any_req && !i_dac_busy;
    gnt_a    = grant && pend_a_q && (!pend_b_q || rr_b_last_q);
    gnt_b    = grant && pend_b_q && (!pend_a_q || !rr_b_last_q);
    gnt_code = gnt_a ? slot_a_q : (gnt_b ? slot_b_q : o_code);
  end

  assign o_busy = (state_q != S_IDLE) || any_req;

  // Frame sequencing: wait for busy to rise, then fall, then hold off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_WAIT_START;
          cnt_d   = '0;
        end
      end
      S_WAIT_START: begin
        if (i_dac_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Driver never started: treat the frame as sent and move on.
          state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!i_dac_busy) begin
          state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and hold-off counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending slots: a new value always lands; a same-cycle grant takes the old one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_a_q  <= '0;
      slot_b_q  <= '0;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      pend_pd_q <= 1'b0;
    end else begin
      if (i_a_valid) begin
        slot_a_q <= i_a_data;
        pend_a_q <= 1'b1;
      end else if (gnt_a) begin
        pend_a_q <= 1'b0;
      end
      if (i_b_valid) begin
        slot_b_q <= i_b_data;
        pend_b_q <= 1'b1;
      end else if (gnt_b) begin
        pend_b_q <= 1'b0;
      end
      // Every frame carries the current mode, so any grant satisfies a mode change.
      if (grant) begin
        pend_pd_q <= 1'b0;
      end else if (i_pd_mode != mode_q) begin
        pend_pd_q <= 1'b1;
      end
    end
  end

  // Frame issue: registered write pulse, frame, last code/source and mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dac_wr      <= 1'b0;
      o_dac_wr_data <= '0;
      o_code        <= '0;
      o_src         <= 1'b0;
      mode_q        <= 2'b00;
      rr_b_last_q   <= 1'b1;
    end else begin
      o_dac_wr <= grant;
      if (grant) begin
        o_dac_wr_data <= {6'b0, i_pd_mode, gnt_code};
        o_code        <= gnt_code;
        mode_q        <= i_pd_mode;
        if (gnt_a || gnt_b) begin
          o_src       <= gnt_b;
          rr_b_last_q <= gnt_b;
        end
      end
    end
  end

`ifdef DAC8551_ARB_STATS_EN
  // Count values overwritten while still pending (not taken by a same-cycle grant).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a_drops <= '0;
      o_b_drops <= '0;
    end else begin
      if (i_a_valid && pend_a_q && !gnt_a) o_a_drops <= sat_inc8(o_a_drops);
      if (i_b_valid && pend_b_q && !gnt_b) o_b_drops <= sat_inc8(o_b_drops);
    end
  end
`endif

endmodule

// File: tb/tb_dac8551_arb.sv
// Directed testbench for dac8551_arb with a simple driver model that raises
// busy for FRAME cycles after each accepted write pulse.
module tb_dac8551_arb;
  localparam int HOLDOFF       = 16;
  localparam int START_TIMEOUT = 4;
  localparam int FRAME         = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_a_valid = 1'b0;
  logic [15:0] i_a_data = '0;
  logic        i_b_valid = 1'b0;
  logic [15:0] i_b_data = '0;
  logic [1:0]  i_pd_mode = 2'b00;
  logic        o_dac_wr;
  logic [23:0] o_dac_wr_data;
  logic        i_dac_busy;
  logic [15:0] o_code;
  logic        o_src;
  logic        o_busy;
`ifdef DAC8551_ARB_STATS_EN
  logic [7:0]  o_a_drops;
  logic [7:0]  o_b_drops;
`endif

  dac8551_arb #(.HOLDOFF(HOLDOFF), .START_TIMEOUT(START_TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_a_valid    (i_a_valid),
    .i_a_data     (i_a_data),
    .i_b_valid    (i_b_valid),
    .i_b_data     (i_b_data),
    .i_pd_mode    (i_pd_mode),
    .o_dac_wr     (o_dac_wr),
    .o_dac_wr_data(o_dac_wr_data),
    .i_dac_busy   (i_dac_busy),
    .o_code       (o_code),
    .o_src        (o_src),
    .o_busy       (o_busy)
`ifdef DAC8551_ARB_STATS_EN
    ,
    .o_a_drops    (o_a_drops),
    .o_b_drops    (o_b_drops)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int busy_viol = 0;
  logic [23:0] data_log [64];
  logic        src_log  [64];
  int          cyc_log  [64];
  bit drv_en = 1'b1;
  logic [7:0] bcnt;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Driver model: busy rises the cycle after a pulse is accepted.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bcnt <= '0;
    else if (drv_en && o_dac_wr) bcnt <= 8'(FRAME);
    else if (bcnt != 0) bcnt <= bcnt - 8'd1;
  end
  assign i_dac_busy = (bcnt != 0);

  // Pulse log sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_dac_wr) begin
      if (pulse_cnt < 64) begin
        data_log[pulse_cnt] = o_dac_wr_data;
        src_log[pulse_cnt]  = o_src;
        cyc_log[pulse_cnt]  = cyc;
      end
      pulse_cnt++;
      if (i_dac_busy) busy_viol++;
    end
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    i_pd_mode = 2'b00;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic pulse_a(input logic [15:0] d);
    i_a_valid = 1'b1;
    i_a_data  = d;
    @(negedge i_clk);
    i_a_valid = 1'b0;
  endtask

  task automatic pulse_b(input logic [15:0] d);
    i_b_valid = 1'b1;
    i_b_data  = d;
    @(negedge i_clk);
    i_b_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while ((o_busy || i_dac_busy) && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_busy || i_dac_busy) begin
      errors++;
      $display("FAIL %s idle_timeout: o_busy=%0b i_dac_busy=%0b required both 0", tag, o_busy, i_dac_busy);
    end
  endtask

  task automatic wait_busy(input int limit, input string tag);
    int n = 0;
    while (!i_dac_busy && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (!i_dac_busy) begin
      errors++;
      $display("FAIL %s busy_timeout: i_dac_busy=0 required 1", tag);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks += 5;
    if (o_dac_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", o_dac_wr); end
    if (o_dac_wr_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", o_dac_wr_data); end
    if (o_code !== 16'h0) begin errors++; $display("FAIL reset_code got %h want 0000", o_code); end
    if (o_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", o_src); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
`ifdef DAC8551_ARB_STATS_EN
    checks++;
    if (o_a_drops !== 8'd0 || o_b_drops !== 8'd0) begin
      errors++; $display("FAIL reset_drops got %0d/%0d want 0/0", o_a_drops, o_b_drops);
    end
`endif
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    pulse_a(16'h1234);
    checks++;
    if (o_dac_wr !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", o_dac_wr); end
    @(negedge i_clk);
    checks += 4;
    if (o_dac_wr !== 1'b1) begin errors++; $display("FAIL single_wr got %0b want 1", o_dac_wr); end
    if (o_dac_wr_data !== 24'h001234) begin errors++; $display("FAIL single_data got %h want 001234", o_dac_wr_data); end
    if (o_code !== 16'h1234) begin errors++; $display("FAIL single_code got %h want 1234", o_code); end
    if (o_src !== 1'b0) begin errors++; $display("FAIL single_src got %0b want 0", o_src); end
    @(negedge i_clk);
    checks++;
    if (o_dac_wr !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b want 0", o_dac_wr); end
    wait_idle(200, "single");
  endtask

  task automatic test_tie();
    int base;
    do_reset();
    base = pulse_cnt;
    i_a_valid = 1'b1; i_a_data = 16'h1111;
    i_b_valid = 1'b1; i_b_data = 16'h2222;
    @(negedge i_clk);
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    wait_idle(300, "tie");
    checks++;
    if (pulse_cnt - base !== 2) begin
      errors++; $display("FAIL tie_count got %0d want 2", pulse_cnt - base);
    end else begin
      checks += 5;
      if (data_log[base] !== 24'h001111) begin errors++; $display("FAIL tie_first got %h want 001111", data_log[base]); end
      if (src_log[base] !== 1'b0) begin errors++; $display("FAIL tie_first_src got %0b want 0", src_log[base]); end
      if (data_log[base+1] !== 24'h002222) begin errors++; $display("FAIL tie_second got %h want 002222", data_log[base+1]); end
      if (src_log[base+1] !== 1'b1) begin errors++; $display("FAIL tie_second_src got %0b want 1", src_log[base+1]); end
      if (cyc_log[base+1] - cyc_log[base] < FRAME + HOLDOFF + 2) begin
        errors++; $display("FAIL tie_spacing got %0d want >= %0d", cyc_log[base+1] - cyc_log[base], FRAME + HOLDOFF + 2);
      end
    end
  endtask

  task automatic test_coalesce();
    int base;
    base = pulse_cnt;
    pulse_a(16'h5555);
    wait_busy(10, "coalesce");
    i_b_valid = 1'b1; i_b_data = 16'hAAAA;
    @(negedge i_clk);
    i_b_data = 16'hBBBB;
    @(negedge i_clk);
    i_b_data = 16'hCCCC;
    @(negedge i_clk);
    i_b_valid = 1'b0;
    wait_idle(300, "coalesce");
    checks++;
    if (pulse_cnt - base !== 2) begin
      errors++; $display("FAIL coalesce_count got %0d want 2", pulse_cnt - base);
    end else begin
      checks += 2;
      if (data_log[base] !== 24'h005555) begin errors++; $display("FAIL coalesce_a got %h want 005555", data_log[base]); end
      if (data_log[base+1] !== 24'h00CCCC) begin errors++; $display("FAIL coalesce_b got %h want 00CCCC", data_log[base+1]); end
    end
    checks += 2;
    if (o_code !== 16'hCCCC) begin errors++; $display("FAIL coalesce_code got %h want CCCC", o_code); end
    if (o_src !== 1'b1) begin errors++; $display("FAIL coalesce_src got %0b want 1", o_src); end
`ifdef DAC8551_ARB_STATS_EN
    checks += 2;
    if (o_b_drops !== 8'd2) begin errors++; $display("FAIL coalesce_b_drops got %0d want 2", o_b_drops); end
    if (o_a_drops !== 8'd0) begin errors++; $display("FAIL coalesce_a_drops got %0d want 0", o_a_drops); end
`endif
  endtask

  task automatic test_pd();
    int base;
    pulse_b(16'h8000);
    repeat (2) @(negedge i_clk);
    wait_idle(300, "pd_setup");
    base = pulse_cnt;
    i_pd_mode = 2'b11;
    repeat (3) @(negedge i_clk);
    wait_idle(300, "pd");
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++; $display("FAIL pd_count got %0d want 1", pulse_cnt - base);
    end else begin
      checks++;
      if (data_log[base] !== 24'h038000) begin errors++; $display("FAIL pd_frame got %h want 038000", data_log[base]); end
    end
    checks += 2;
    if (o_src !== 1'b1) begin errors++; $display("FAIL pd_src got %0b want 1", o_src); end
    if (o_code !== 16'h8000) begin errors++; $display("FAIL pd_code got %h want 8000", o_code); end
    repeat (40) @(negedge i_clk);
    checks++;
    if (pulse_cnt - base !== 1) begin errors++; $display("FAIL pd_hold got %0d frames want 1", pulse_cnt - base); end
    i_pd_mode = 2'b00;
    repeat (3) @(negedge i_clk);
    wait_idle(300, "pd_restore");
  endtask

  task automatic test_timeout();
    int base;
    drv_en = 1'b0;
    base = pulse_cnt;
    pulse_a(16'h0AAA);
    @(negedge i_clk);
    pulse_a(16'h0BBB);
    repeat (2) @(negedge i_clk);
    wait_idle(300, "timeout");
    checks++;
    if (pulse_cnt - base !== 2) begin
      errors++; $display("FAIL timeout_count got %0d want 2", pulse_cnt - base);
    end else begin
      checks += 3;
      if (data_log[base] !== 24'h000AAA) begin errors++; $display("FAIL timeout_first got %h want 000AAA", data_log[base]); end
      if (data_log[base+1] !== 24'h000BBB) begin errors++; $display("FAIL timeout_second got %h want 000BBB", data_log[base+1]); end
      if (cyc_log[base+1] - cyc_log[base] !== START_TIMEOUT + HOLDOFF + 1) begin
        errors++; $display("FAIL timeout_spacing got %0d want %0d", cyc_log[base+1] - cyc_log[base], START_TIMEOUT + HOLDOFF + 1);
      end
    end
    drv_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_a(16'h0123);
    wait_busy(10, "reset_mid");
    repeat (2) @(negedge i_clk);
    pulse_b(16'h4444);
    #2 i_rst_n = 1'b0;
    #1;
    checks += 5;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", o_busy); end
    if (o_code !== 16'h0) begin errors++; $display("FAIL rstmid_code got %h want 0000", o_code); end
    if (o_dac_wr_data !== 24'h0) begin errors++; $display("FAIL rstmid_data got %h want 000000", o_dac_wr_data); end
    if (o_src !== 1'b0) begin errors++; $display("FAIL rstmid_src got %0b want 0", o_src); end
    if (o_dac_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %0b want 0", o_dac_wr); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    base = pulse_cnt;
    repeat (60) @(negedge i_clk);
    checks += 2;
    if (pulse_cnt !== base) begin errors++; $display("FAIL rstmid_no_frame got %0d frames want 0", pulse_cnt - base); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %0b want 0", o_busy); end
    pulse_a(16'h0777);
    repeat (2) @(negedge i_clk);
    wait_idle(300, "reset_mid_after");
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++; $display("FAIL rstmid_after_count got %0d want 1", pulse_cnt - base);
    end else begin
      checks++;
      if (data_log[base] !== 24'h000777) begin errors++; $display("FAIL rstmid_after_data got %h want 000777", data_log[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_coalesce();
    test_pd();
    test_timeout();
    test_reset_mid();
    checks++;
    if (busy_viol !== 0) begin errors++; $display("FAIL wr_during_busy got %0d want 0", busy_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
